// File: rtl/dbus_sram_responder_pkg.sv
// Shared data-bus types plus the responder's FSM state and latency-counter width.
package dbus_sram_responder_pkg;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dbus_state_e;

    // LATENCY tops out at 15, so the WAIT preload (LATENCY-2) fits in 4 bits.
    localparam int unsigned DBUS_CNT_W = 4;

endpackage

// File: rtl/dbus_sram_responder_sram.sv
// Single-port DEPTH_WORDS x 64 backing store: byte write enables, combinational read.
// No reset on purpose: contents survive a responder reset.
module dbus_sram
#(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned AW          = $clog2(DEPTH_WORDS)
)
(
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [7:0]    i_be,
    input  logic [AW-1:0] i_addr,
    input  logic [63:0]   i_wdata,
    output logic [63:0]   o_rdata
);

    logic [63:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < 8; b++) begin
                if (i_be[b]) begin
                    r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/dbus_sram_responder.sv
// Fixed-latency data-bus responder in front of a byte-writable SRAM.
// state | meaning: IDLE = accept dreq | WAIT = count down latency | RESP = one-cycle handshake, write commits
module dbus_sram_responder
    import dbus_sram_responder_pkg::*;
#(
    parameter int unsigned LATENCY     = 2,
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter logic [63:0] BASE_ADDR   = 64'h8000_0000
)
(
    input  logic       clk,
    input  logic       reset,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output logic       busy,
    output logic       access_err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam logic [63:0] SPAN = 64'(DEPTH_WORDS) << 3;
    localparam logic [DBUS_CNT_W-1:0] CNT_INIT =
        (LATENCY >= 2) ? DBUS_CNT_W'(LATENCY - 2) : '0;

    dbus_state_e           r_state;
    dbus_state_e           w_next_state;
    logic [DBUS_CNT_W-1:0] r_cnt;
    logic [DBUS_CNT_W-1:0] w_cnt_next;
    logic                  w_accept;
    logic [63:0]           r_addr;
    logic [7:0]            r_strobe;
    logic [63:0]           r_data;
    logic                  r_err;

    logic [63:0]           w_off;
    logic                  w_in_range;
    logic [AW-1:0]         w_index;
    logic                  w_we;
    logic                  w_read;
    logic [63:0]           w_rdata;
    logic                  w_unused;

    // Offset-based compare: BASE_ADDR + SPAN itself could overflow 64 bits.
    assign w_off      = r_addr - BASE_ADDR;
    assign w_in_range = (r_addr >= BASE_ADDR) && (w_off < SPAN);
    assign w_index    = w_off[AW+2:3];
    assign w_we       = (r_state == ST_RESP) && w_in_range && (r_strobe != 8'h00);
    assign w_read     = (r_state == ST_RESP) && w_in_range && (r_strobe == 8'h00);
    assign w_unused   = ^{dreq.size, w_off[63:AW+3], w_off[2:0]};

    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (dreq.valid) begin
                    w_accept     = 1'b1;
                    w_cnt_next   = CNT_INIT;
                    w_next_state = (LATENCY == 1) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!dreq.valid) begin
                    w_next_state = ST_IDLE;
                    w_cnt_next   = '0;
                end else if (r_cnt == '0) begin
                    w_next_state = ST_RESP;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            ST_RESP: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_addr   <= '0;
            r_strobe <= '0;
            r_data   <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_addr   <= dreq.addr;
                r_strobe <= dreq.strobe;
                r_data   <= dreq.data;
            end
            if ((r_state == ST_RESP) && !w_in_range) begin
                r_err <= 1'b1;
            end
        end
    end

    always_comb begin
        dresp = '0;
        if (r_state == ST_RESP) begin
            dresp.addr_ok = 1'b1;
            dresp.data_ok = 1'b1;
            dresp.data    = w_read ? w_rdata : 64'h0;
        end
    end

    assign busy       = (r_state != ST_IDLE);
    assign access_err = r_err;

    dbus_sram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_sram (
        .i_clk   (clk),
        .i_we    (w_we),
        .i_be    (r_strobe),
        .i_addr  (w_index),
        .i_wdata (r_data),
        .o_rdata (w_rdata)
    );

endmodule

// File: doc/dbus_sram_responder.md
DBUS_SRAM_RESPONDER -- requirements
Module: dbus_sram_responder

Interface
REQ-001 Parameters: LATENCY, default 2, cycles from request accept to data_ok (legal 1..15).
REQ-002 Parameters: DEPTH_WORDS, default 4096, number of 64-bit backing words (power of two).
REQ-003 Parameters: BASE_ADDR, default 64'h8000_0000, byte address of word 0.
REQ-004 Port: clk  in  1  single clock; all state on its rising edge.
REQ-005 Port: reset  in  1  asynchronous, active-low reset.
REQ-006 Port: dreq  in  dbus_req_t  initiator request (valid, addr, size, strobe, data).
REQ-007 Port: dresp  out  dbus_resp_t  response (addr_ok, data_ok, data).
REQ-008 Port: busy  out  1  high when the FSM is not IDLE.
REQ-009 Port: access_err  out  1  sticky out-of-range flag.

Function
REQ-010 FSM states: IDLE, WAIT, RESP.
REQ-011 IDLE, dreq.valid=1 in cycle t: latch addr, strobe, data; go WAIT with cnt=LATENCY-2, or RESP directly if LATENCY=1.
REQ-012 WAIT: cnt decrements each cycle; at cnt=0 go RESP; dresp.data_ok asserts exactly in cycle t+LATENCY.
REQ-013 WAIT with dreq.valid=0: abort, go IDLE next cycle, no write, no data_ok.
REQ-014 RESP: addr_ok=data_ok=1 for exactly one cycle, then IDLE unconditionally, even if valid dropped that cycle.
REQ-015 Outside RESP: addr_ok=data_ok=0, data=64'h0.
REQ-016 Index = (latched addr - BASE_ADDR) >> 3; addr[2:0] ignored for indexing.
REQ-017 Read (strobe==0): dresp.data = stored word at index in RESP cycle, all 8 bytes, size ignored.
REQ-018 Write (strobe!=0): bytes with strobe[i]=1 take data[8i+7:8i] at the rising edge ending RESP; others unchanged; dresp.data=64'h0.
REQ-019 Request latched in IDLE; dreq changes during WAIT/RESP other than valid are ignored.
REQ-020 Out of range (addr<BASE_ADDR or addr>=BASE_ADDR+8*DEPTH_WORDS): write dropped, read returns 64'h0, access_err set; handshake timing unchanged.
REQ-021 Back-to-back: next request is sampled no earlier than the IDLE cycle after RESP; minimum issue interval LATENCY+1 cycles.
REQ-022 Address arithmetic 64-bit, no wrap; subtraction below base is caught by REQ-020 before indexing.

Reset
REQ-023 Reset low: FSM=IDLE, cnt=0, latched request cleared, busy=0, access_err=0, dresp all zero, asynchronously.
REQ-024 Reset during WAIT/RESP: pending request discarded, no write, no data_ok after release.
REQ-025 Backing storage is not cleared by reset; contents persist across reset.

Structure
REQ-026 dbus_req_t/dbus_resp_t come from the shared common package; no local redefinition.
REQ-027 FSM state enum and LATENCY counter width belong in the shared package beside the bus types.
REQ-028 Storage is one sub-module dbus_sram: single port, byte-write-enable, combinational read, DEPTH_WORDS x 64.
REQ-029 dbus_sram_responder holds only FSM, counter, request latch, range check and flag.

Verification
REQ-030 LATENCY=2, read 0x8000_0010 preloaded 64'hDEAD_BEEF_0123_4567, valid at t -> data_ok=1 only in t+2, data=64'hDEAD_BEEF_0123_4567.
REQ-031 Write 0x8000_0008, strobe 8'h0F, data 64'h1111_2222_3333_4444 over word 64'hFFFF_FFFF_FFFF_FFFF, then read -> 64'hFFFF_FFFF_3333_4444.
REQ-032 Read 0x7FFF_FFF8 and write 0x8000_8000 (DEPTH_WORDS=4096) -> data_ok at t+2, read data 64'h0, write dropped, access_err=1 until reset.
REQ-033 Write accepted, valid dropped in WAIT -> no data_ok, word unchanged, busy=0 next cycle.
REQ-034 Reset asserted in RESP-1 cycle of a write -> no data_ok, word unchanged, access_err=0; contents elsewhere preserved.
REQ-035 LATENCY=1, three back-to-back reads -> data_ok every 2nd cycle, correct data each, busy toggling.
